// File: rtl/inside_match_pkg.sv
// Shared types and helpers for the set-membership comparator: index width,
// pipeline result record and the power-on table contents.
package inside_match_pkg;

    localparam int MAX_IDX_W = 16;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 hit;
        logic [MAX_IDX_W-1:0] idx;
        logic                 mux;
    } result_t;

    // Entry i powers up holding the constant i; callers truncate to their width.
    function automatic logic [31:0] init_entry(input int unsigned i);
        return 32'(i);
    endfunction

endpackage

// File: rtl/inside_match_table.sv
// Programmable constant table with per-entry enables, a single write port and a
// combinational match vector reduced to (any hit, lowest matching index).
module inside_match_table
    import inside_match_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int N_ENTRIES = 4,
    parameter int IDX_W     = idx_w(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_val,
    input  logic              wr_ent_en,
    input  logic [DATA_W-1:0] cmp_d,
    output logic              match_hit,
    output logic [IDX_W-1:0]  match_idx
);

    logic [DATA_W-1:0]    tbl_q [N_ENTRIES];
    logic [DATA_W-1:0]    tbl_d [N_ENTRIES];
    logic [N_ENTRIES-1:0] en_q;
    logic [N_ENTRIES-1:0] en_d;
    logic [N_ENTRIES-1:0] hit_vec;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        logic [31:0] full;
        full = init_entry(i);
        return full[DATA_W-1:0];
    endfunction

    // Out-of-range indices simply never match any entry, so they are dropped.
    always_comb begin
        tbl_d = tbl_q;
        en_d  = en_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                tbl_d[i] = wr_val;
                en_d[i]  = wr_ent_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                tbl_q[i] <= init_val(i);
            end
            en_q <= '1;
        end else begin
            tbl_q <= tbl_d;
            en_q  <= en_d;
        end
    end

    // Scanning downward leaves the lowest matching index as the final winner.
    always_comb begin
        match_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            hit_vec[i] = en_q[i] && (cmp_d == tbl_q[i]);
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                match_idx = IDX_W'(i);
            end
        end
        match_hit = |hit_vec;
    end

endmodule

// File: rtl/inside_set_match_mux.sv
// Streaming `d inside {T[]}` test driving mux = hit ? a : b through a two-stage
// valid/ready pipeline, with saturating hit/miss counters on delivered results.
module inside_set_match_mux
    import inside_match_pkg::*;
#(
    parameter int  DATA_W    = 4,
    parameter int  N_ENTRIES = 4,
    parameter int  CNT_W     = 8,
    localparam int IDX_W     = idx_w(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_val,
    input  logic              cfg_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_d,
    input  logic              in_a,
    input  logic              in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mux,
    output logic              out_hit,
    output logic [IDX_W-1:0]  out_hit_idx,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    input  logic              stat_clr
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_d_q, s1_d_d;
    logic              s1_a_q, s1_a_d;
    logic              s1_b_q, s1_b_d;
    logic              s2_valid_q, s2_valid_d;
    result_t           res_q, res_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic              s1_ready, s2_ready, out_fire;
    logic              match_hit;
    logic [IDX_W-1:0]  match_idx;
    logic              unused_res;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    inside_match_table #(
        .DATA_W    (DATA_W),
        .N_ENTRIES (N_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (cfg_we),
        .wr_idx    (cfg_idx),
        .wr_val    (cfg_val),
        .wr_ent_en (cfg_en),
        .cmp_d     (s1_d_q),
        .match_hit (match_hit),
        .match_idx (match_idx)
    );

    // Ready only looks at registered state, so in_valid never reaches in_ready.
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d_d     = s1_d_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d_d = in_d;
                s1_a_d = in_a;
                s1_b_d = in_b;
            end
        end
        // The compare is sampled here, against the table as it stands before this edge.
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d                = '0;
                res_d.hit            = match_hit;
                res_d.idx[IDX_W-1:0] = match_idx;
                res_d.mux            = match_hit ? s1_a_q : s1_b_q;
            end
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stat_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (out_fire) begin
            if (res_q.hit) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_d_q     <= '0;
            s1_a_q     <= 1'b0;
            s1_b_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_d_q     <= s1_d_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_hit     = res_q.hit;
    assign out_mux     = res_q.mux;
    assign out_hit_idx = res_q.idx[IDX_W-1:0];
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;
    assign unused_res  = ^res_q.idx;

endmodule

// File: tb/tb_inside_set_match_mux.sv
// Directed bench for inside_set_match_mux; a second instance with 2-bit counters
// shares all inputs so counter saturation can be observed.
module tb_inside_set_match_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [3:0] cfg_val = '0;
    logic       cfg_en = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_d = '0;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic       out_ready = 1'b1;
    logic       stat_clr = 1'b0;

    logic       in_ready, out_valid, out_mux, out_hit;
    logic [1:0] out_hit_idx;
    logic [7:0] hit_count, miss_count;

    logic       in_ready2, out_valid2, out_mux2, out_hit2;
    logic [1:0] out_hit_idx2;
    logic [1:0] hit_count2, miss_count2;

    int checks = 0;
    int errors = 0;

    inside_set_match_mux #(.DATA_W(4), .N_ENTRIES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_val(cfg_val),
        .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_mux(out_mux), .out_hit(out_hit), .out_hit_idx(out_hit_idx),
        .hit_count(hit_count), .miss_count(miss_count), .stat_clr(stat_clr)
    );

    inside_set_match_mux #(.DATA_W(4), .N_ENTRIES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_val(cfg_val),
        .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready2), .in_d(in_d),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_mux(out_mux2), .out_hit(out_hit2), .out_hit_idx(out_hit_idx2),
        .hit_count(hit_count2), .miss_count(miss_count2), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic hit, input logic [1:0] idx,
                              input logic mux);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hit"}, 32'(out_hit), 32'(hit));
        chk({tag, "_idx"}, 32'(out_hit_idx), 32'(idx));
        chk({tag, "_mux"}, 32'(out_mux), 32'(mux));
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [3:0] val, input logic en);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_val = val;
        cfg_en  = en;
        step();
        cfg_we  = 1'b0;
    endtask

    // One sample in, then wait until it sits at the output (out_ready assumed high).
    task automatic send_one(input logic [3:0] d, input logic a, input logic b);
        in_valid = 1'b1;
        in_d     = d;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        step();
    endtask

    logic [3:0] seq [6];
    int         sent, rcvd, extra;
    logic [3:0] ed;
    logic       eh, ea;
    logic       acc;

    initial begin
        seq = '{4'd1, 4'd5, 4'd3, 4'd0, 4'd2, 4'd6};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_hit", 32'(out_hit), 32'd0);
        chk("rst_out_mux", 32'(out_mux), 32'd0);
        chk("rst_out_idx", 32'(out_hit_idx), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Test 1: default table, sweep 0..15 back to back
        for (int i = 0; i <= 16; i++) begin
            in_valid = (i < 16);
            in_d     = i[3:0];
            in_a     = 1'b1;
            in_b     = 1'b0;
            step();
            if (i == 0) begin
                chk("t1_latency", 32'(out_valid), 32'd0);
            end else begin
                eh = ((i - 1) < 4);
                expect_out($sformatf("t1_d%0d", i - 1), eh, eh ? 2'(i - 1) : 2'd0, eh);
            end
        end
        in_valid = 1'b0;
        step();
        chk("t1_hit_count", 32'(hit_count), 32'd4);
        chk("t1_miss_count", 32'(miss_count), 32'd12);
        chk("t1_drained", 32'(out_valid), 32'd0);

        // Test 2: write T[2]=9 in the cycle sample A is compared; B right behind sees it
        in_valid = 1'b1;
        in_d     = 4'd9;
        in_a     = 1'b1;
        in_b     = 1'b0;
        step();
        cfg_we   = 1'b1;
        cfg_idx  = 2'd2;
        cfg_val  = 4'd9;
        cfg_en   = 1'b1;
        step();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        expect_out("t2_old_entry", 1'b0, 2'd0, 1'b0);
        step();
        expect_out("t2_new_entry", 1'b1, 2'd2, 1'b1);
        step();
        cfg_write(2'd2, 4'd2, 1'b1);

        // Test 3: backpressure with scoreboard
        sent  = 0;
        rcvd  = 0;
        extra = 0;
        for (int c = 0; c < 24; c++) begin
            out_ready = (c >= 7);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_d = seq[sent];
                in_a = sent[0];
                in_b = ~sent[0];
            end
            #1;
            if (c >= 2 && c < 7) begin
                chk($sformatf("t3_stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
                expect_out($sformatf("t3_stall_c%0d", c), 1'b1, 2'd1, 1'b0);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (rcvd < 6) begin
                    ed = seq[rcvd];
                    ea = rcvd[0];
                    eh = (ed < 4'd4);
                    expect_out($sformatf("t3_item%0d", rcvd), eh, eh ? ed[1:0] : 2'd0,
                               eh ? ea : ~ea);
                    rcvd++;
                end else begin
                    extra++;
                end
            end
            if (acc) sent++;
            step();
        end
        chk("t3_sent", 32'(sent), 32'd6);
        chk("t3_received", 32'(rcvd), 32'd6);
        chk("t3_no_extra", 32'(extra), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;

        // Test 4: duplicates with a disabled lower entry, then everything disabled
        cfg_write(2'd1, 4'd7, 1'b0);
        cfg_write(2'd3, 4'd7, 1'b1);
        send_one(4'd7, 1'b1, 1'b0);
        expect_out("t4_dup", 1'b1, 2'd3, 1'b1);
        for (int i = 0; i < 4; i++) cfg_write(2'(i), 4'(i), 1'b0);
        send_one(4'd0, 1'b1, 1'b0);
        expect_out("t4_alloff_b0", 1'b0, 2'd0, 1'b0);
        send_one(4'd0, 1'b0, 1'b1);
        expect_out("t4_alloff_b1", 1'b0, 2'd0, 1'b1);

        // Test 5: saturation on the 2-bit instance, clear beats concurrent increment
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("t5_clr_hit", 32'(hit_count), 32'd0);
        chk("t5_clr_miss", 32'(miss_count), 32'd0);
        chk("t5_clr_hit2", 32'(hit_count2), 32'd0);
        cfg_write(2'd0, 4'd0, 1'b1);
        repeat (5) send_one(4'd0, 1'b1, 1'b0);
        step();
        chk("t5_hit_count5", 32'(hit_count), 32'd5);
        chk("t5_hit_count_sat", 32'(hit_count2), 32'd3);
        chk("t5_miss_sat_inst", 32'(miss_count2), 32'd0);
        send_one(4'd0, 1'b1, 1'b0);
        expect_out("t5_pending", 1'b1, 2'd0, 1'b1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("t5_clr_vs_inc", 32'(hit_count), 32'd0);
        chk("t5_clr_vs_inc2", 32'(hit_count2), 32'd0);
        chk("t5_fired", 32'(out_valid), 32'd0);

        // Test 6: reset with two samples held in the pipeline
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_d      = 4'd0;
        in_a      = 1'b1;
        in_b      = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        chk("t6_inflight", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_hit", 32'(out_hit), 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t6_no_ghost", 32'(out_valid), 32'd0);
        chk("t6_hit_count", 32'(hit_count), 32'd0);
        send_one(4'd1, 1'b1, 1'b0);
        expect_out("t6_tbl1", 1'b1, 2'd1, 1'b1);
        send_one(4'd3, 1'b1, 1'b0);
        expect_out("t6_tbl3", 1'b1, 2'd3, 1'b1);
        send_one(4'd2, 1'b1, 1'b0);
        expect_out("t6_tbl2", 1'b1, 2'd2, 1'b1);
        send_one(4'd7, 1'b1, 1'b0);
        expect_out("t6_seven_miss", 1'b0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
